// File: rtl/planta_pkg.sv
// Shared constants and slot-state bundle for the bottling-line plant emulator.
// LFSR constants are consumed only when PLANTA_LFSR_DEFEITO_EN is defined.
package planta_pkg;

  localparam int unsigned N_POS_DEF    = 8;
  localparam int unsigned POS_ENCH_DEF = 2;
  localparam int unsigned POS_VED_DEF  = 4;
  localparam int unsigned POS_CQ_DEF   = 6;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned LFSR_W = 8;

  // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci register: taps on bits 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

  typedef struct packed {
    logic occ;
    logic cheia;
    logic vedada;
    logic marca;
  } slot_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/planta_slot_shift.sv
// Conveyor slot store: per-slot bottle state with discard clear, shift/insert,
// and in-place fill/seal marking while the belt is stopped.
module planta_slot_shift
  import planta_pkg::*;
#(
  parameter int unsigned N_POS    = N_POS_DEF,
  parameter int unsigned POS_ENCH = POS_ENCH_DEF,
  parameter int unsigned POS_VED  = POS_VED_DEF,
  parameter int unsigned POS_CQ   = POS_CQ_DEF
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  step,
  input  logic  discard,
  input  logic  insert,
  input  logic  insert_marca,
  input  logic  set_cheia,
  input  logic  set_vedada,
  output logic  ench_occ,
  output logic  ench_cheia,
  output logic  ved_occ,
  output slot_t cq_slot,
  output logic  exit_occ
);

  slot_t [N_POS-1:0] slots;
  slot_t [N_POS-1:0] slots_nxt;
  slot_t             new_slot;

  // Discard acts first so the shift moves the post-discard contents.
  always_comb begin
    new_slot       = '0;
    new_slot.occ   = insert;
    new_slot.marca = insert & insert_marca;
    slots_nxt      = slots;
    if (discard && slots[POS_CQ].occ) begin
      slots_nxt[POS_CQ] = '0;
    end
    if (step) begin
      slots_nxt = {slots_nxt[N_POS-2:0], new_slot};
    end else begin
      if (set_cheia) begin
        slots_nxt[POS_ENCH].cheia = 1'b1;
      end
      if (set_vedada) begin
        slots_nxt[POS_VED].vedada = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slots <= '0;
    end else begin
      slots <= slots_nxt;
    end
  end

  assign ench_occ   = slots[POS_ENCH].occ;
  assign ench_cheia = slots[POS_ENCH].cheia;
  assign ved_occ    = slots[POS_VED].occ;
  assign cq_slot    = slots[POS_CQ];
  assign exit_occ   = slots[N_POS-1].occ;

endmodule

// File: rtl/planta_envase.sv
// Bottling-line plant emulator: turns controller actuators into line sensors.
// Define PLANTA_LFSR_DEFEITO_EN for pseudo-random defect marking instead of DEF_PERIOD.
module planta_envase
  import planta_pkg::*;
#(
  parameter int unsigned N_POS      = N_POS_DEF,
  parameter int unsigned POS_ENCH   = POS_ENCH_DEF,
  parameter int unsigned POS_VED    = POS_VED_DEF,
  parameter int unsigned POS_CQ     = POS_CQ_DEF,
  parameter int unsigned FEED_GAP   = 3,
  parameter int unsigned FILL_TICKS = 4,
  parameter int unsigned DEF_PERIOD = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             motor,
  input  logic             ev,
  input  logic             ve,
  input  logic             descarte,
  output logic             garrafa,
  output logic             sensor_de_nivel,
  output logic             sensor_cq,
  output logic             defeito,
  output logic             erro_derrame,
  output logic [CNT_W-1:0] garrafas_produzidas,
  output logic [CNT_W-1:0] garrafas_descartadas
);

  localparam int unsigned FEED_W  = (FEED_GAP > 1) ? $clog2(FEED_GAP) : 1;
  localparam int unsigned NIVEL_W = 4;

  logic [FEED_W-1:0]  feed_cnt;
  logic [NIVEL_W-1:0] nivel;
  logic               erro;
  logic               insert;
  logic               new_marca;
  logic               fill_en;
  logic               set_cheia;
  logic               set_vedada;
  logic               discard_hit;
  logic               ench_occ;
  logic               ench_cheia;
  logic               ved_occ;
  logic               exit_occ;
  slot_t              cq_slot;

  assign insert      = motor && (feed_cnt == '0);
  assign fill_en     = !motor && ev && ench_occ;
  assign set_cheia   = fill_en && (nivel == NIVEL_W'(FILL_TICKS - 1));
  assign set_vedada  = !motor && ve && ved_occ;
  assign discard_hit = descarte && cq_slot.occ;

  planta_slot_shift #(
    .N_POS    (N_POS),
    .POS_ENCH (POS_ENCH),
    .POS_VED  (POS_VED),
    .POS_CQ   (POS_CQ)
  ) u_slots (
    .clk          (clk),
    .reset        (reset),
    .step         (motor),
    .discard      (descarte),
    .insert       (insert),
    .insert_marca (new_marca),
    .set_cheia    (set_cheia),
    .set_vedada   (set_vedada),
    .ench_occ     (ench_occ),
    .ench_cheia   (ench_cheia),
    .ved_occ      (ved_occ),
    .cq_slot      (cq_slot),
    .exit_occ     (exit_occ)
  );

  // Feed spacing, fill level, spill flag and production/discard tallies.
  always_ff @(posedge clk) begin
    if (reset) begin
      feed_cnt             <= '0;
      nivel                <= '0;
      erro                 <= 1'b0;
      garrafas_produzidas  <= '0;
      garrafas_descartadas <= '0;
    end else begin
      if (discard_hit) begin
        garrafas_descartadas <= sat_inc(garrafas_descartadas);
      end
      if (motor) begin
        if (exit_occ) begin
          garrafas_produzidas <= sat_inc(garrafas_produzidas);
        end
        feed_cnt <= insert ? FEED_W'(FEED_GAP - 1) : feed_cnt - FEED_W'(1);
        nivel    <= '0;
        if (ev) begin
          erro <= 1'b1;
        end
      end else if (fill_en && (nivel != NIVEL_W'(FILL_TICKS))) begin
        nivel <= nivel + NIVEL_W'(1);
      end
    end
  end

`ifdef PLANTA_LFSR_DEFEITO_EN
  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (insert) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign new_marca = lfsr[0];
`else
  logic [CNT_W-1:0] ins_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      ins_cnt <= '0;
    end else if (insert) begin
      ins_cnt <= ins_cnt + CNT_W'(1);
    end
  end

  // Ordinal of the bottle being inserted is 1-based, so it is ins_cnt + 1.
  if (DEF_PERIOD != 0) begin : g_mark
    logic [CNT_W:0] ins_ord;
    assign ins_ord   = {1'b0, ins_cnt} + (CNT_W+1)'(1);
    assign new_marca = ((ins_ord % (CNT_W+1)'(DEF_PERIOD)) == '0);
  end else begin : g_nomark
    assign new_marca = 1'b0;
  end
`endif

  assign garrafa         = ench_occ;
  assign sensor_de_nivel = ench_cheia;
  assign sensor_cq       = cq_slot.occ;
  assign defeito         = cq_slot.occ & (cq_slot.marca | ~cq_slot.cheia | ~cq_slot.vedada);
  assign erro_derrame    = erro;

endmodule

// File: tb/tb_planta_envase.sv
// Self-checking bench for planta_envase (default build, DEF_PERIOD marking).
module tb_planta_envase;

  localparam int FEED_GAP   = 3;
  localparam int FILL_TICKS = 4;
  localparam int DEF_PERIOD = 5;

  logic       clk = 1'b0;
  logic       reset, motor, ev, ve, descarte;
  logic       garrafa, sensor_de_nivel, sensor_cq, defeito, erro_derrame;
  logic [7:0] garrafas_produzidas, garrafas_descartadas;

  planta_envase dut (
    .clk                  (clk),
    .reset                (reset),
    .motor                (motor),
    .ev                   (ev),
    .ve                   (ve),
    .descarte             (descarte),
    .garrafa              (garrafa),
    .sensor_de_nivel      (sensor_de_nivel),
    .sensor_cq            (sensor_cq),
    .defeito              (defeito),
    .erro_derrame         (erro_derrame),
    .garrafas_produzidas  (garrafas_produzidas),
    .garrafas_descartadas (garrafas_descartadas)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef logic [20:0] outv_t;
  outv_t exp_q[$];

  // Behavioural line model
  bit m_occ[8], m_cheia[8], m_ved[8], m_mar[8];
  int m_nivel, m_feed, m_ins, m_prod, m_desc;
  bit m_err;

  function automatic outv_t model_outs();
    bit d;
    d = m_occ[6] & (m_mar[6] | !m_cheia[6] | !m_ved[6]);
    return {m_occ[2], m_cheia[2], m_occ[6], d, m_err, 8'(m_prod), 8'(m_desc)};
  endfunction

  task automatic model_step(input bit r, input bit m, input bit e, input bit v, input bit d);
    if (r) begin
      for (int i = 0; i < 8; i++) begin
        m_occ[i] = 0; m_cheia[i] = 0; m_ved[i] = 0; m_mar[i] = 0;
      end
      m_nivel = 0; m_feed = 0; m_ins = 0; m_prod = 0; m_desc = 0; m_err = 0;
      return;
    end
    if (d && m_occ[6]) begin
      m_occ[6] = 0; m_cheia[6] = 0; m_ved[6] = 0; m_mar[6] = 0;
      if (m_desc < 255) m_desc++;
    end
    if (m) begin
      if (e) m_err = 1;
      if (m_occ[7] && m_prod < 255) m_prod++;
      for (int i = 7; i > 0; i--) begin
        m_occ[i] = m_occ[i-1]; m_cheia[i] = m_cheia[i-1];
        m_ved[i] = m_ved[i-1]; m_mar[i] = m_mar[i-1];
      end
      m_cheia[0] = 0; m_ved[0] = 0;
      if (m_feed == 0) begin
        m_occ[0] = 1;
        m_mar[0] = ((m_ins + 1) % DEF_PERIOD) == 0;
        m_ins    = (m_ins + 1) % 256;
        m_feed   = FEED_GAP - 1;
      end else begin
        m_occ[0] = 0; m_mar[0] = 0;
        m_feed--;
      end
      m_nivel = 0;
    end else begin
      if (e && m_occ[2] && m_nivel < FILL_TICKS) begin
        m_nivel++;
        if (m_nivel == FILL_TICKS) m_cheia[2] = 1;
      end
      if (v && m_occ[4]) m_ved[4] = 1;
    end
  endtask

  // Drive one clock of stimulus and queue the model's expected outputs.
  task automatic cycle(input bit r, input bit m, input bit e, input bit v, input bit d);
    reset = r; motor = m; ev = e; ve = v; descarte = d;
    model_step(r, m, e, v, d);
    exp_q.push_back(model_outs());
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: pop one expectation per edge and compare the full output vector.
  always @(posedge clk) begin
    outv_t got, exp;
    #1;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {garrafa, sensor_de_nivel, sensor_cq, defeito, erro_derrame,
             garrafas_produzidas, garrafas_descartadas};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL scoreboard t=%0t got=%h exp=%h", $time, got, exp);
      end
    end
  end

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0);
    checks++;
    if ({garrafa, sensor_de_nivel, sensor_cq, defeito, erro_derrame} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=00000",
               {garrafa, sensor_de_nivel, sensor_cq, defeito, erro_derrame});
    end
    checks++;
    if ({garrafas_produzidas, garrafas_descartadas} !== 16'h0) begin
      errors++;
      $display("FAIL reset_counters got=%h exp=0000", {garrafas_produzidas, garrafas_descartadas});
    end
  endtask

  task automatic test_feed();
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    checks++;
    if (garrafa !== 1'b0) begin
      errors++; $display("FAIL feed_step2 got=%b exp=0", garrafa);
    end
    cycle(0, 1, 0, 0, 0);
    checks++;
    if (garrafa !== 1'b1) begin
      errors++; $display("FAIL feed_step3 got=%b exp=1", garrafa);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
    checks++;
    if (sensor_de_nivel !== 1'b0) begin
      errors++; $display("FAIL fill_tick3 got=%b exp=0", sensor_de_nivel);
    end
    cycle(0, 0, 1, 0, 0);
    checks++;
    if (sensor_de_nivel !== 1'b1) begin
      errors++; $display("FAIL fill_tick4 got=%b exp=1", sensor_de_nivel);
    end
    cycle(0, 0, 1, 0, 0);
    checks++;
    if (sensor_de_nivel !== 1'b1) begin
      errors++; $display("FAIL fill_tick5 got=%b exp=1", sensor_de_nivel);
    end
  endtask

  task automatic test_spill();
    cycle(0, 1, 1, 0, 0);
    checks++;
    if (erro_derrame !== 1'b1) begin
      errors++; $display("FAIL spill_set got=%b exp=1", erro_derrame);
    end
    for (int i = 0; i < 20; i++) cycle(0, bit'(i % 2), 0, 0, 0);
    checks++;
    if (erro_derrame !== 1'b1) begin
      errors++; $display("FAIL spill_sticky got=%b exp=1", erro_derrame);
    end
    cycle(1, 0, 0, 0, 0);
    checks++;
    if (erro_derrame !== 1'b0) begin
      errors++; $display("FAIL spill_clear got=%b exp=0", erro_derrame);
    end
  endtask

  task automatic test_seal_discard();
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) cycle(0, 1, 0, 0, 0);
    checks++;
    if ({sensor_cq, defeito} !== 2'b10) begin
      errors++; $display("FAIL good_at_cq got=%b exp=10", {sensor_cq, defeito});
    end
    cycle(0, 0, 0, 0, 1);
    checks++;
    if ({sensor_cq, garrafas_descartadas} !== {1'b0, 8'd1}) begin
      errors++;
      $display("FAIL discard got cq=%b desc=%0d exp cq=0 desc=1", sensor_cq, garrafas_descartadas);
    end
  endtask

  task automatic test_stream();
    cycle(1, 0, 0, 0, 0);
    for (int s = 1; s <= 12; s++) begin
      cycle(0, 1, 0, 0, 0);
      if (sensor_cq) begin
        checks++;
        if (defeito !== 1'b1) begin
          errors++; $display("FAIL unfilled_defect step=%0d got=%b exp=1", s, defeito);
        end
      end
      if (s == 8 || s == 9) begin
        checks++;
        if (garrafas_produzidas !== ((s == 9) ? 8'd1 : 8'd0)) begin
          errors++;
          $display("FAIL produced step=%0d got=%0d exp=%0d", s, garrafas_produzidas, (s == 9) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_serviced();
    int k;
    k = 0;
    cycle(1, 0, 0, 0, 0);
    for (int s = 1; s <= 40; s++) begin
      cycle(0, 1, 0, 0, 0);
      for (int i = 0; i < FILL_TICKS; i++) cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 0, 1, 0);
      if (sensor_cq) begin
        k++;
        checks++;
        if (defeito !== bit'(k % DEF_PERIOD == 0)) begin
          errors++;
          $display("FAIL serviced_defect bottle=%0d got=%b exp=%b", k, defeito, bit'(k % DEF_PERIOD == 0));
        end
      end
    end
    checks++;
    if (k != 12) begin
      errors++; $display("FAIL serviced_count got=%0d exp=12", k);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(1, 1, 1, 0, 1);
    checks++;
    if ({garrafa, sensor_de_nivel, sensor_cq, defeito, erro_derrame} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_flags got=%b exp=00000",
               {garrafa, sensor_de_nivel, sensor_cq, defeito, erro_derrame});
    end
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
    checks++;
    if (garrafa !== 1'b1) begin
      errors++; $display("FAIL midreset_insert got=%b exp=1", garrafa);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
    checks++;
    if (sensor_de_nivel !== 1'b0) begin
      errors++; $display("FAIL midreset_nivel got=%b exp=0", sensor_de_nivel);
    end
    cycle(0, 0, 1, 0, 0);
    checks++;
    if (sensor_de_nivel !== 1'b1) begin
      errors++; $display("FAIL midreset_fill got=%b exp=1", sensor_de_nivel);
    end
  endtask

  task automatic test_saturation();
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 800; i++) cycle(0, 1, 0, 0, 0);
    checks++;
    if (garrafas_produzidas !== 8'd255) begin
      errors++; $display("FAIL produced_sat got=%0d exp=255", garrafas_produzidas);
    end
    for (int i = 0; i < 820; i++) cycle(0, 1, 0, 0, 1);
    checks++;
    if ({garrafas_produzidas, garrafas_descartadas} !== {8'd255, 8'd255}) begin
      errors++;
      $display("FAIL discard_sat got prod=%0d desc=%0d exp 255 255",
               garrafas_produzidas, garrafas_descartadas);
    end
  endtask

  initial begin
    reset = 1'b1; motor = 1'b0; ev = 1'b0; ve = 1'b0; descarte = 1'b0;
    test_reset();
    test_feed();
    test_fill();
    test_spill();
    test_seal_discard();
    test_stream();
    test_serviced();
    test_reset_mid();
    test_saturation();
    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
